// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the 5-stage MIPS core.
// Holds the opcode/funct encodings used by decode-side control-transfer logic,
// the fetch start address, the nop word, and a small decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    // Fetch start address and the bubble word loaded on clear/reset
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Kind of control transfer encoded by an instruction word
    typedef enum logic [2:0] {
        XF_NONE,
        XF_BEQ,
        XF_BNE,
        XF_J,
        XF_JAL,
        XF_JR,
        XF_JALR
    } xfer_e;

    function automatic xfer_e decode_xfer(input logic [31:0] instr);
        xfer_e kind;
        kind = XF_NONE;
        case (instr[31:26])
            OP_BEQ:   kind = XF_BEQ;
            OP_BNE:   kind = XF_BNE;
            OP_J:     kind = XF_J;
            OP_JAL:   kind = XF_JAL;
            OP_RTYPE: begin
                if (instr[5:0] == FN_JR)
                    kind = XF_JR;
                else if (instr[5:0] == FN_JALR)
                    kind = XF_JALR;
            end
            default:  kind = XF_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/id_branch_stage_if.sv
// -----------------------------------------------------------------------------
// id_branch_stage_if
// Bundles the IF-side inputs, hazard controls, forwarded operands and the
// decode-stage outputs of id_branch_stage.
//   master : drives if_pc/if_instr/stall/clr/rs_val/rt_val, observes D outputs
//   slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface id_branch_stage_if;

    logic [31:0] if_pc;        // PC of the instruction in IF
    logic [31:0] if_instr;     // instruction word in IF
    logic        stall;        // hold IF/ID register
    logic        clr;          // load a bubble instead of the IF instruction
    logic [31:0] rs_val;       // forwarded GPR[rs] for the D instruction
    logic [31:0] rt_val;       // forwarded GPR[rt] for the D instruction

    logic [31:0] npc;          // next fetch address
    logic [31:0] d_pc;         // PC of the D instruction
    logic [31:0] d_instr;      // D instruction word (0 = nop)
    logic        d_valid;      // D holds a real instruction
    logic [4:0]  d_rs;         // instr[25:21]
    logic [4:0]  d_rt;         // instr[20:16]
    logic        br_taken;     // D control transfer taken this cycle
    logic        d_link;       // D is jal/jalr
    logic [31:0] d_link_addr;  // d_pc + 8

    modport master (
        output if_pc, if_instr, stall, clr, rs_val, rt_val,
        input  npc, d_pc, d_instr, d_valid, d_rs, d_rt,
               br_taken, d_link, d_link_addr
    );

    modport slave (
        input  if_pc, if_instr, stall, clr, rs_val, rt_val,
        output npc, d_pc, d_instr, d_valid, d_rs, d_rt,
               br_taken, d_link, d_link_addr
    );

endinterface

// File: rtl/branch_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
// 32-bit equality comparator for branch resolution in D.
//   i_a, i_b : forwarded operands
//   o_eq     : i_a == i_b
//   o_ne     : i_a != i_b
// -----------------------------------------------------------------------------
module branch_cmp (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_eq,
    output logic        o_ne
);

    logic w_eq;

    assign w_eq = (i_a == i_b);
    assign o_eq = w_eq;
    assign o_ne = ~w_eq;

endmodule

// File: rtl/id_branch_stage.sv
// -----------------------------------------------------------------------------
// id_branch_stage
// Decode-side stage behind the fetch unit. Holds the IF/ID register with
// stall/clear control, resolves beq/bne/j/jal/jr/jalr in D from forwarded
// operands and returns the next fetch address. One architectural delay slot:
// the IF instruction is never squashed by a taken transfer.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : id_branch_stage_if.slave (IF inputs, hazard controls, forwarded
//           operands in; npc and D-stage decode outputs out)
// -----------------------------------------------------------------------------
module id_branch_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    id_branch_stage_if.slave   bus
);

    import cpu_defs::*;

    // The fetch unit starts at RESET_PC and all npc arithmetic here is plain
    // +4 / word-offset math, so a misaligned start would never realign.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_misaligned
    end

    logic [31:0] r_pc_p1;
    logic [31:0] r_instr_p1;
    logic        r_vld_p1;

    // ---- IF -> D boundary: IF/ID pipeline register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_p1    <= 32'h0000_0000;
            r_instr_p1 <= NOP;
            r_vld_p1   <= 1'b0;
        end else if (!bus.stall) begin
            r_pc_p1 <= bus.if_pc;
            if (bus.clr) begin
                r_instr_p1 <= NOP;
                r_vld_p1   <= 1'b0;
            end else begin
                r_instr_p1 <= bus.if_instr;
                r_vld_p1   <= 1'b1;
            end
        end
    end

    // ---- D stage: decode, compare, target select ----
    logic        w_eq;
    logic        w_ne;
    xfer_e       w_xfer;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic        w_xfer_taken;
    logic        w_is_link;
    logic        w_br_taken;

    branch_cmp u_cmp (
        .i_a  (bus.rs_val),
        .i_b  (bus.rt_val),
        .o_eq (w_eq),
        .o_ne (w_ne)
    );

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    always_comb begin
        w_xfer       = decode_xfer(r_instr_p1);
        w_pc_plus4   = r_pc_p1 + 32'd4;
        w_br_target  = w_pc_plus4 + branch_offset(r_instr_p1[15:0]);
        w_j_target   = {w_pc_plus4[31:28], r_instr_p1[25:0], 2'b00};
        w_target     = w_pc_plus4;
        w_xfer_taken = 1'b0;
        w_is_link    = 1'b0;
        case (w_xfer)
            XF_BEQ:  begin w_xfer_taken = w_eq; w_target = w_br_target; end
            XF_BNE:  begin w_xfer_taken = w_ne; w_target = w_br_target; end
            XF_J:    begin w_xfer_taken = 1'b1; w_target = w_j_target;  end
            XF_JAL:  begin w_xfer_taken = 1'b1; w_target = w_j_target;  w_is_link = 1'b1; end
            XF_JR:   begin w_xfer_taken = 1'b1; w_target = bus.rs_val;  end
            XF_JALR: begin w_xfer_taken = 1'b1; w_target = bus.rs_val;  w_is_link = 1'b1; end
            default: begin w_xfer_taken = 1'b0; w_target = w_pc_plus4;  end
        endcase
    end

    // A bubble in D must never redirect fetch or request a link write, even
    // though its zero word decodes cleanly.
    assign w_br_taken = r_vld_p1 & w_xfer_taken;

    // Computed regardless of stall; the fetch unit is disabled while stalled,
    // so a pending redirect lands on the first non-stalled edge.
    assign bus.npc         = w_br_taken ? w_target : (bus.if_pc + 32'd4);
    assign bus.br_taken    = w_br_taken;
    assign bus.d_link      = r_vld_p1 & w_is_link;
    assign bus.d_link_addr = r_pc_p1 + 32'd8;
    assign bus.d_pc        = r_pc_p1;
    assign bus.d_instr     = r_instr_p1;
    assign bus.d_valid     = r_vld_p1;
    assign bus.d_rs        = r_instr_p1[25:21];
    assign bus.d_rt        = r_instr_p1[20:16];

endmodule

// File: tb/tb_id_branch_stage.sv
// -----------------------------------------------------------------------------
// tb_id_branch_stage
// Directed bench for id_branch_stage. Expected D-stage outputs are pushed to a
// scoreboard queue when stimulus is applied and popped/compared once outputs
// have settled.
// -----------------------------------------------------------------------------
module tb_id_branch_stage;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    id_branch_stage_if bus ();

    id_branch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        vld;
        logic        br;
        logic        link;
        logic [31:0] laddr;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [31:0] pc, input logic [31:0] instr);
        bus.if_pc    = pc;
        bus.if_instr = instr;
    endtask

    task automatic set_fwd(input logic [31:0] rs, input logic [31:0] rt);
        bus.rs_val = rs;
        bus.rt_val = rt;
    endtask

    task automatic push(input string tag, input logic [31:0] npc,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic vld, input logic br, input logic link);
        exp_t e;
        e.tag   = tag;
        e.npc   = npc;
        e.pc    = pc;
        e.instr = instr;
        e.vld   = vld;
        e.br    = br;
        e.link  = link;
        e.laddr = pc + 32'd8;
        e.rs    = instr[25:21];
        e.rt    = instr[20:16];
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".npc"},       bus.npc,                 e.npc);
        chk({e.tag, ".d_pc"},      bus.d_pc,                e.pc);
        chk({e.tag, ".d_instr"},   bus.d_instr,             e.instr);
        chk({e.tag, ".d_valid"},   {31'd0, bus.d_valid},    {31'd0, e.vld});
        chk({e.tag, ".br_taken"},  {31'd0, bus.br_taken},   {31'd0, e.br});
        chk({e.tag, ".d_link"},    {31'd0, bus.d_link},     {31'd0, e.link});
        chk({e.tag, ".link_addr"}, bus.d_link_addr,         e.laddr);
        chk({e.tag, ".d_rs"},      {27'd0, bus.d_rs},       {27'd0, e.rs});
        chk({e.tag, ".d_rt"},      {27'd0, bus.d_rt},       {27'd0, e.rt});
    endtask

    initial begin
        // Reset
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.clr   = 1'b0;
        set_if(32'h0000_3000, 32'h0000_0000);
        set_fwd(32'd0, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        push("reset", 32'h3004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_check();

        // First load: nop at 3000
        cyc();
        set_if(32'h0000_3004, 32'h1022_FFFF);
        push("load0", 32'h3008, 32'h3000, 32'h0, 1'b1, 1'b0, 1'b0);
        pop_check();

        // beq -1 taken: target = 3004 + 4 - 4
        set_fwd(32'd5, 32'd5);
        cyc();
        set_if(32'h0000_3008, 32'h1422_0003);
        push("beq_taken", 32'h3004, 32'h3004, 32'h1022_FFFF, 1'b1, 1'b1, 1'b0);
        pop_check();

        // Delay slot loaded; bne not taken, then taken once rt_val changes
        cyc();
        set_if(32'h0000_3004, 32'h0000_0000);
        push("bne_nt", 32'h3008, 32'h3008, 32'h1422_0003, 1'b1, 1'b0, 1'b0);
        pop_check();
        set_fwd(32'd5, 32'd6);
        push("bne_t", 32'h3018, 32'h3008, 32'h1422_0003, 1'b1, 1'b1, 1'b0);
        pop_check();

        // jal at 3010
        set_if(32'h0000_3010, 32'h0C00_0C10);
        cyc();
        set_if(32'h0000_3014, 32'h0020_0008);
        push("jal", 32'h3040, 32'h3010, 32'h0C00_0C10, 1'b1, 1'b1, 1'b1);
        pop_check();

        // jr $1
        set_fwd(32'h0000_301C, 32'd0);
        cyc();
        set_if(32'h0000_3018, 32'h0020_F809);
        push("jr", 32'h301C, 32'h3014, 32'h0020_0008, 1'b1, 1'b1, 1'b0);
        pop_check();

        // jalr $31,$1
        set_fwd(32'h0000_4000, 32'd0);
        cyc();
        set_if(32'h0000_3020, 32'h0800_0400);
        push("jalr", 32'h4000, 32'h3018, 32'h0020_F809, 1'b1, 1'b1, 1'b1);
        pop_check();

        // j 0x1000
        cyc();
        set_if(32'h0000_3024, 32'h0022_1820);
        push("j", 32'h1000, 32'h3020, 32'h0800_0400, 1'b1, 1'b1, 1'b0);
        pop_check();

        // add: not a control transfer
        cyc();
        set_if(32'h0000_3100, 32'h1022_FFFF);
        push("rtype", 32'h3104, 32'h3024, 32'h0022_1820, 1'b1, 1'b0, 1'b0);
        pop_check();

        // beq in D under stall; operand forwarding resolves mid-stall
        set_fwd(32'd1, 32'd2);
        cyc();
        set_if(32'h0000_3104, 32'h2401_0001);
        bus.stall = 1'b1;
        push("stall_pre", 32'h3108, 32'h3100, 32'h1022_FFFF, 1'b1, 1'b0, 1'b0);
        pop_check();
        cyc();
        push("stall1", 32'h3108, 32'h3100, 32'h1022_FFFF, 1'b1, 1'b0, 1'b0);
        pop_check();
        set_fwd(32'd2, 32'd2);
        cyc();
        push("stall2", 32'h3100, 32'h3100, 32'h1022_FFFF, 1'b1, 1'b1, 1'b0);
        pop_check();
        cyc();
        push("stall3", 32'h3100, 32'h3100, 32'h1022_FFFF, 1'b1, 1'b1, 1'b0);
        pop_check();
        bus.stall = 1'b0;
        cyc();
        push("unstall", 32'h3108, 32'h3104, 32'h2401_0001, 1'b1, 1'b0, 1'b0);
        pop_check();

        // clr with a beq in IF: bubble, pc still follows IF
        set_if(32'h0000_3200, 32'h1022_FFFF);
        bus.clr = 1'b1;
        cyc();
        set_if(32'h0000_3204, 32'h0000_0000);
        push("clr", 32'h3208, 32'h3200, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_check();

        // clr together with stall: stall wins, registers hold
        set_if(32'h0000_3204, 32'h0C00_0C10);
        bus.stall = 1'b1;
        cyc();
        push("clr_stall", 32'h3208, 32'h3200, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_check();
        bus.stall = 1'b0;
        bus.clr   = 1'b0;

        // Reset while a taken jal sits in D
        set_if(32'h0000_3300, 32'h0C00_0C10);
        cyc();
        set_if(32'h0000_3304, 32'h0000_0000);
        push("jal2", 32'h3040, 32'h3300, 32'h0C00_0C10, 1'b1, 1'b1, 1'b1);
        pop_check();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        push("rst_mid", 32'h3308, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_check();

        // Wrap-around of sequential npc and of branch arithmetic
        set_if(32'hFFFF_FFFC, 32'h1022_0000);
        push("wrap_npc", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_check();
        set_fwd(32'd7, 32'd7);
        cyc();
        set_if(32'h0000_0000, 32'h0000_0000);
        push("wrap_br", 32'h0, 32'hFFFF_FFFC, 32'h1022_0000, 1'b1, 1'b1, 1'b0);
        pop_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
